ysyx_23060184_ifu: RTL and testbench

YSYX_23060184_IFU -- requirements
Module: ysyx_23060184_IFU

---
 rtl/ysyx_23060184_ifu.sv | 116 +++++++++++
 tb/tb_ysyx_23060184_ifu.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060184_ifu.sv
// Instruction fetch unit: takes a PC, reads one word over AXI4-Lite
// and holds it for decode until it is accepted or flushed.
module ysyx_23060184_ifu #(
    parameter int DATA_WIDTH       = 32,
    parameter bit ADDR_ALIGN_CHECK = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Pvalid,
    input  logic [DATA_WIDTH-1:0] PC,
    output logic                  Iready,
    input  logic                  Flush,
    output logic                  Ivalid,
    input  logic                  Dready,
    output logic [DATA_WIDTH-1:0] Inst,
    output logic [DATA_WIDTH-1:0] InstPC,
    output logic                  Ierr,
    output logic [DATA_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [31:0]           FetchCnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AREQ,
        S_RWAIT,
        S_HOLD
    } state_t;

    state_t                r_state;
    logic                  r_kill;
    logic [DATA_WIDTH-1:0] r_inst;
    logic [DATA_WIDTH-1:0] r_pc;
    logic                  r_ierr;
    logic [31:0]           r_cnt;

    logic w_accept;
    logic w_misalign;
    logic w_kill;

    // Flush blocks acceptance; a flush on the data beat itself also kills.
    assign w_accept   = (r_state == S_IDLE) && Pvalid && !Flush;
    assign w_misalign = ADDR_ALIGN_CHECK && (PC[1:0] != 2'b00);
    assign w_kill     = r_kill || Flush;

    // Fetch sequencer; all handshake outputs decode the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_kill  <= 1'b0;
            r_inst  <= '0;
            r_pc    <= '0;
            r_ierr  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_kill <= 1'b0;
                    if (w_accept) begin
                        r_pc <= PC;
                        if (w_misalign) begin
                            r_inst  <= '0;
                            r_ierr  <= 1'b1;
                            r_state <= S_HOLD;
                        end else begin
                            r_state <= S_AREQ;
                        end
                    end
                end
                S_AREQ: begin
                    if (Flush) r_kill <= 1'b1;
                    if (arready) r_state <= S_RWAIT;
                end
                S_RWAIT: begin
                    if (rvalid) begin
                        if (w_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_inst  <= rdata;
                            r_ierr  <= (rresp != 2'b00);
                            r_state <= S_HOLD;
                        end
                    end else if (Flush) begin
                        r_kill <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (Flush) begin
                        r_state <= S_IDLE;
                    end else if (Dready) begin
                        r_cnt   <= r_cnt + 32'd1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Iready   = (r_state == S_IDLE);
    assign arvalid  = (r_state == S_AREQ);
    assign rready   = (r_state == S_RWAIT);
    assign Ivalid   = (r_state == S_HOLD);
    assign araddr   = r_pc;
    assign InstPC   = r_pc;
    assign Inst     = r_inst;
    assign Ierr     = r_ierr;
    assign FetchCnt = r_cnt;

endmodule

// File: tb/tb_ysyx_23060184_ifu.sv
// Bench for ysyx_23060184_ifu: directed scenarios plus randomized
// transactions checked against a transaction-level fetch model.
module tb_ysyx_23060184_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        Pvalid;
    logic [31:0] PC;
    logic        Iready;
    logic        Flush;
    logic        Ivalid;
    logic        Dready;
    logic [31:0] Inst;
    logic [31:0] InstPC;
    logic        Ierr;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] FetchCnt;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cnt  = 32'd0;

    always #5 clk = ~clk;

    ysyx_23060184_ifu dut (
        .clk      (clk),
        .rst      (rst),
        .Pvalid   (Pvalid),
        .PC       (PC),
        .Iready   (Iready),
        .Flush    (Flush),
        .Ivalid   (Ivalid),
        .Dready   (Dready),
        .Inst     (Inst),
        .InstPC   (InstPC),
        .Ierr     (Ierr),
        .araddr   (araddr),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready),
        .FetchCnt (FetchCnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_iready"}, Iready, 1);
        chk({tag, "_arvalid"}, arvalid, 0);
        chk({tag, "_araddr"}, araddr, 0);
        chk({tag, "_rready"}, rready, 0);
        chk({tag, "_ivalid"}, Ivalid, 0);
        chk({tag, "_inst"}, Inst, 0);
        chk({tag, "_instpc"}, InstPC, 0);
        chk({tag, "_ierr"}, Ierr, 0);
        chk({tag, "_cnt"}, FetchCnt, 0);
    endtask

    // One randomized fetch; expectations come from the fetch rules:
    // address wait, data wait, then hold until taken or flushed.
    task automatic rand_txn();
        logic [31:0] pc;
        logic [31:0] val;
        logic [31:0] e_inst;
        logic [1:0]  resp;
        bit          mis;
        bit          kill;
        bit          e_err;
        int          ard;
        int          rd;
        int          dd;
        int          total;
        int          fl_at;
        int          step;
        pc   = $urandom & 32'hFFFF_FFFC;
        mis  = ($urandom_range(0, 7) == 0);
        if (mis) pc[1:0] = 2'($urandom_range(1, 3));
        val  = $urandom;
        resp = ($urandom_range(0, 5) == 0) ?
               2'($urandom_range(1, 3)) : 2'b00;
        ard   = $urandom_range(0, 3);
        rd    = $urandom_range(0, 3);
        dd    = $urandom_range(0, 3);
        total = ard + rd + 2;
        fl_at = $urandom_range(0, 3 * total);
        kill  = !mis && (fl_at < total);
        e_inst = mis ? 32'd0 : val;
        e_err  = mis || (resp != 2'b00);
        chk("r_idle_iready", Iready, 1);
        Pvalid = 1'b1;
        PC     = pc;
        tick();
        Pvalid = 1'b0;
        PC     = $urandom;
        if (!mis) begin
            step = 0;
            for (int d = 0; d <= ard; d++) begin
                arready = (d == ard);
                Flush   = (step == fl_at);
                chk("r_arvalid", arvalid, 1);
                chk("r_araddr", araddr, pc);
                chk("r_ar_noiv", Ivalid, 0);
                tick();
                step++;
            end
            arready = 1'b0;
            Flush   = 1'b0;
            for (int d = 0; d <= rd; d++) begin
                rvalid = (d == rd);
                rdata  = (d == rd) ? val : $urandom;
                rresp  = resp;
                Flush  = (step == fl_at);
                chk("r_rready", rready, 1);
                chk("r_r_noiv", Ivalid, 0);
                tick();
                step++;
            end
            rvalid = 1'b0;
            rresp  = 2'b00;
            Flush  = 1'b0;
            if (kill) begin
                chk("r_kill_iready", Iready, 1);
                chk("r_kill_noiv", Ivalid, 0);
                chk("r_kill_cnt", FetchCnt, exp_cnt);
                return;
            end
        end else begin
            chk("r_mis_noar", arvalid, 0);
        end
        chk("r_ivalid", Ivalid, 1);
        chk("r_inst", Inst, e_inst);
        chk("r_instpc", InstPC, pc);
        chk("r_ierr", Ierr, e_err);
        for (int d = 0; d < dd; d++) begin
            Dready = 1'b0;
            tick();
            chk("r_hold_iv", Ivalid, 1);
            chk("r_hold_inst", Inst, e_inst);
            chk("r_hold_pc", InstPC, pc);
        end
        if ($urandom_range(0, 7) == 0) begin
            Flush  = 1'b1;
            Dready = 1'($urandom_range(0, 1));
            tick();
            Flush  = 1'b0;
            Dready = 1'b0;
            chk("r_hflush_iv", Ivalid, 0);
            chk("r_hflush_cnt", FetchCnt, exp_cnt);
        end else begin
            Dready = 1'b1;
            tick();
            Dready = 1'b0;
            exp_cnt = exp_cnt + 32'd1;
            chk("r_done_iv", Ivalid, 0);
            chk("r_done_cnt", FetchCnt, exp_cnt);
        end
    endtask

    initial begin
        rst     = 1'b1;
        Pvalid  = 1'b0;
        PC      = 32'd0;
        Flush   = 1'b0;
        Dready  = 1'b0;
        arready = 1'b0;
        rdata   = 32'd0;
        rresp   = 2'b00;
        rvalid  = 1'b0;
        tick();
        tick();
        chk_reset_vals("rst");
        rst = 1'b0;
        tick();

        // Basic fetch with zero-wait slave
        Pvalid  = 1'b1;
        PC      = 32'h2000_0000;
        arready = 1'b1;
        rvalid  = 1'b1;
        rdata   = 32'h0000_0413;
        Dready  = 1'b1;
        tick();
        Pvalid = 1'b0;
        chk("b_arvalid", arvalid, 1);
        chk("b_araddr", araddr, 32'h2000_0000);
        tick();
        chk("b_rready", rready, 1);
        chk("b_noiv", Ivalid, 0);
        tick();
        chk("b_ivalid", Ivalid, 1);
        chk("b_inst", Inst, 32'h0000_0413);
        chk("b_instpc", InstPC, 32'h2000_0000);
        chk("b_ierr", Ierr, 0);
        tick();
        exp_cnt = 32'd1;
        chk("b_cnt", FetchCnt, exp_cnt);
        chk("b_iready", Iready, 1);

        // Backpressure on both address and decode sides
        Pvalid  = 1'b1;
        PC      = 32'h2000_0010;
        arready = 1'b0;
        rvalid  = 1'b0;
        Dready  = 1'b0;
        tick();
        Pvalid = 1'b0;
        PC     = 32'h0BAD_0000;
        for (int i = 0; i < 4; i++) begin
            chk("bp_arvalid", arvalid, 1);
            chk("bp_araddr", araddr, 32'h2000_0010);
            tick();
        end
        chk("bp_arvalid", arvalid, 1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid  = 1'b1;
        rdata   = 32'h1234_5678;
        tick();
        rvalid = 1'b0;
        rdata  = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ivalid", Ivalid, 1);
            chk("bp_inst", Inst, 32'h1234_5678);
            chk("bp_cnt_hold", FetchCnt, exp_cnt);
            tick();
        end
        Dready = 1'b1;
        chk("bp_ivalid", Ivalid, 1);
        tick();
        Dready  = 1'b0;
        exp_cnt = 32'd2;
        chk("bp_cnt", FetchCnt, exp_cnt);
        chk("bp_noiv", Ivalid, 0);

        // Flush while waiting for read data
        Pvalid  = 1'b1;
        PC      = 32'h2000_0020;
        arready = 1'b1;
        tick();
        Pvalid = 1'b0;
        tick();
        arready = 1'b0;
        Flush   = 1'b1;
        tick();
        Flush = 1'b0;
        chk("fr_rready", rready, 1);
        tick();
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
        chk("fr_rready2", rready, 1);
        chk("fr_noiv", Ivalid, 0);
        tick();
        rvalid = 1'b0;
        chk("fr_iready", Iready, 1);
        chk("fr_noiv2", Ivalid, 0);
        tick();
        chk("fr_noiv3", Ivalid, 0);
        chk("fr_cnt", FetchCnt, exp_cnt);

        // Bus error response
        Pvalid  = 1'b1;
        PC      = 32'h2000_0030;
        arready = 1'b1;
        rvalid  = 1'b1;
        rresp   = 2'b10;
        rdata   = 32'hCAFE_F00D;
        tick();
        Pvalid = 1'b0;
        tick();
        tick();
        rvalid  = 1'b0;
        arready = 1'b0;
        rresp   = 2'b00;
        chk("be_ivalid", Ivalid, 1);
        chk("be_ierr", Ierr, 1);
        chk("be_inst", Inst, 32'hCAFE_F00D);
        Dready = 1'b1;
        tick();
        Dready  = 1'b0;
        exp_cnt = 32'd3;
        chk("be_cnt", FetchCnt, exp_cnt);

        // Misaligned PC: no bus request
        Pvalid = 1'b1;
        PC     = 32'h2000_0002;
        tick();
        Pvalid = 1'b0;
        chk("ma_noar", arvalid, 0);
        chk("ma_ivalid", Ivalid, 1);
        chk("ma_ierr", Ierr, 1);
        chk("ma_inst", Inst, 0);
        chk("ma_instpc", InstPC, 32'h2000_0002);
        Dready = 1'b1;
        tick();
        Dready  = 1'b0;
        exp_cnt = 32'd4;
        chk("ma_cnt", FetchCnt, exp_cnt);

        // Flush in hold with Dready also high
        Pvalid  = 1'b1;
        PC      = 32'h2000_0050;
        arready = 1'b1;
        rvalid  = 1'b1;
        rdata   = 32'h0000_0011;
        tick();
        Pvalid = 1'b0;
        tick();
        tick();
        arready = 1'b0;
        rvalid  = 1'b0;
        chk("fh_ivalid", Ivalid, 1);
        Flush  = 1'b1;
        Dready = 1'b1;
        tick();
        Flush  = 1'b0;
        Dready = 1'b0;
        chk("fh_noiv", Ivalid, 0);
        chk("fh_iready", Iready, 1);
        chk("fh_cnt", FetchCnt, exp_cnt);

        // Flush and Pvalid together in idle
        Flush  = 1'b1;
        Pvalid = 1'b1;
        PC     = 32'h2000_0040;
        tick();
        Flush  = 1'b0;
        Pvalid = 1'b0;
        chk("fp_iready", Iready, 1);
        chk("fp_noar", arvalid, 0);
        chk("fp_instpc", InstPC, 32'h2000_0050);
        tick();
        chk("fp_noar2", arvalid, 0);

        for (int t = 0; t < 60; t++) begin
            rand_txn();
        end

        // Reset while the address request is pending
        Pvalid  = 1'b1;
        PC      = 32'h2000_0060;
        arready = 1'b0;
        tick();
        Pvalid = 1'b0;
        chk("ra_arvalid", arvalid, 1);
        rst = 1'b1;
        tick();
        chk_reset_vals("ra");
        rst = 1'b0;
        tick();
        chk("ra_idle", Iready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
